// File: rtl/num_text_formatter.sv
// Binary-to-text formatter: label slots followed by right-aligned decimal digits, 6-bit char codes.
// Optional NUM_TEXT_ZERO_PAD_EN renders leading zeros as '0' instead of blank.
module num_text_formatter #(
    parameter int unsigned VALUE_WIDTH = 20,
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned LABEL_LEN   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic [LABEL_LEN*6-1:0] label,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [95:0]            text
);

    // Digits needed to hold the largest input, so add-3 never spills for any value.
    localparam int unsigned LOG_DIGITS = (VALUE_WIDTH * 30103) / 100000 + 1;
    localparam int unsigned BCD_DIGITS = (LOG_DIGITS > NUM_DIGITS) ? LOG_DIGITS : NUM_DIGITS;
    localparam int unsigned BCD_W      = BCD_DIGITS * 4;
    localparam int unsigned SHIFT_W    = BCD_W + VALUE_WIDTH;
    localparam int unsigned CNT_W      = $clog2(VALUE_WIDTH + 1);

    localparam logic [5:0] CODE_ZERO = 6'd53;
    localparam logic [5:0] CODE_NINE = 6'd62;
`ifdef NUM_TEXT_ZERO_PAD_EN
    localparam logic [5:0] LEAD_CODE = CODE_ZERO;
`else
    localparam logic [5:0] LEAD_CODE = 6'd0;
`endif

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] SAT_LIMIT = pow10(NUM_DIGITS);

    if ((LABEL_LEN + NUM_DIGITS) > 16) begin : g_bad_layout
        $error("num_text_formatter: LABEL_LEN + NUM_DIGITS must not exceed 16");
    end

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StPack
    } state_e;

    state_e state_q, state_d;

    logic [SHIFT_W-1:0]     shift_q;
    logic [SHIFT_W-1:0]     shift_adj;
    logic [SHIFT_W-1:0]     shift_d;
    logic [LABEL_LEN*6-1:0] label_q;
    logic                   sat_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [95:0]            text_q;
    logic [95:0]            text_d;
    logic                   done_q;
    logic                   overflow_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StConvert;
                end
            end
            StConvert: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StPack;
                end
            end
            StPack: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        case (state_q)
            StConvert, StPack: busy = 1'b1;
            default:           busy = 1'b0;
        endcase
    end

    // Double-dabble step: correct every nibble >= 5, then shift the whole {bcd, value} word.
    always_comb begin
        shift_adj = shift_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (shift_q[VALUE_WIDTH + 4*i +: 4] >= 4'd5) begin
                shift_adj[VALUE_WIDTH + 4*i +: 4] = shift_q[VALUE_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        shift_d = shift_adj << 1;
    end

    // Text assembly from the finished BCD digits; slot order is most significant digit first.
    always_comb begin
        logic       lead;
        logic [3:0] dig;
        logic [5:0] code;
        lead   = 1'b1;
        dig    = 4'd0;
        code   = 6'd0;
        text_d = '0;
        text_d[LABEL_LEN*6-1:0] = label_q;
        for (int unsigned s = 0; s < NUM_DIGITS; s++) begin
            dig = shift_q[VALUE_WIDTH + 4*(NUM_DIGITS - 1 - s) +: 4];
            if ((dig != 4'd0) || (s == NUM_DIGITS - 1)) begin
                lead = 1'b0;
            end
            if (sat_q) begin
                code = CODE_NINE;
            end else if (lead) begin
                code = LEAD_CODE;
            end else begin
                code = CODE_ZERO + {2'b00, dig};
            end
            text_d[(LABEL_LEN + s)*6 +: 6] = code;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            label_q    <= '0;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
            text_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        shift_q <= {{BCD_W{1'b0}}, value};
                        label_q <= label;
                        sat_q   <= (64'(value) >= SAT_LIMIT);
                        cnt_q   <= CNT_W'(VALUE_WIDTH);
                    end
                end
                StConvert: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                StPack: begin
                    text_q     <= text_d;
                    overflow_q <= sat_q;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign text     = text_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
